// File: rtl/room_mode_scheduler.sv
// room_mode_scheduler
//   Mode sequencer for the room controller (heater + lights). Three user
//   buttons and a motion sensor drive a Moore FSM. An inactivity timer starts
//   a timed fade into sleep. All outputs decode only the state register.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   power_btn    raw level, rising edge = power press
//   mode_btn     raw level, rising edge = mode press
//   sleep_btn    raw level, rising edge = sleep press
//   motion       level, high = occupant activity this cycle
//   sysOn        system enable
//   sleep        sleep mode (heater on, lights off)
//   atmospheric  dim/atmospheric light mode
//   lightsSel    white-light select
//   threshold    lights change threshold
//   state        current FSM state encoding (debug)
//
// state  | meaning
// -------+---------------------------------------------------
// OFF    | system disabled, waits for a power press
// NORMAL | default lighting
// WHITE  | white lights selected
// ATMOS  | dim/atmospheric lighting
// FADE   | timed dim before sleep, activity returns to ret_state
// SLEEP  | heater on, lights off
module room_mode_scheduler #(
    parameter int         IDLE_CYCLES = 1000,
    parameter int         FADE_CYCLES = 16,
    parameter logic [5:0] THR_NORMAL  = 6'd32,
    parameter logic [5:0] THR_ATMOS   = 6'd8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       power_btn,
    input  logic       mode_btn,
    input  logic       sleep_btn,
    input  logic       motion,
    output logic       sysOn,
    output logic       sleep,
    output logic       atmospheric,
    output logic       lightsSel,
    output logic [5:0] threshold,
    output logic [2:0] state
);

    localparam int IDLE_W = $clog2(IDLE_CYCLES);
    localparam int FADE_W = (FADE_CYCLES > 1) ? $clog2(FADE_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [FADE_W-1:0] FADE_LAST = FADE_W'(FADE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_NORMAL = 3'd1,
        S_WHITE  = 3'd2,
        S_ATMOS  = 3'd3,
        S_FADE   = 3'd4,
        S_SLEEP  = 3'd5
    } state_t;

    state_t            state_q;
    state_t            state_d;
    state_t            ret_state;
    logic              power_q;
    logic              mode_q;
    logic              sleep_q;
    logic [IDLE_W-1:0] idle_cnt;
    logic [FADE_W-1:0] fade_cnt;

    logic power_p;
    logic mode_p;
    logic sleep_p;
    logic activity;
    logic in_active;

    // Button history resets to 0, so a button held through reset release
    // registers as a press on the first clock.
    assign power_p   = power_btn & ~power_q;
    assign mode_p    = mode_btn  & ~mode_q;
    assign sleep_p   = sleep_btn & ~sleep_q;
    assign activity  = power_p | mode_p | sleep_p | motion;
    assign in_active = (state_q == S_NORMAL) || (state_q == S_WHITE) ||
                       (state_q == S_ATMOS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            power_q <= 1'b0;
            mode_q  <= 1'b0;
            sleep_q <= 1'b0;
        end else begin
            power_q <= power_btn;
            mode_q  <= mode_btn;
            sleep_q <= sleep_btn;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_OFF;
            ret_state <= S_NORMAL;
        end else begin
            state_q <= state_d;
            if (state_d == S_FADE && state_q != S_FADE) begin
                ret_state <= state_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (activity || !in_active) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    // The fade counter is zero on the FADE entry edge and counts the cycles spent in FADE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fade_cnt <= '0;
        end else if (state_q == S_FADE && state_d == S_FADE) begin
            fade_cnt <= fade_cnt + FADE_W'(1);
        end else begin
            fade_cnt <= '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_OFF: begin
                if (power_p) state_d = S_NORMAL;
            end
            S_NORMAL, S_WHITE, S_ATMOS: begin
                if (power_p) begin
                    state_d = S_OFF;
                end else if (sleep_p) begin
                    state_d = S_FADE;
                end else if (mode_p) begin
                    case (state_q)
                        S_NORMAL: state_d = S_WHITE;
                        S_WHITE:  state_d = S_ATMOS;
                        default:  state_d = S_NORMAL;
                    endcase
                end else if (!motion && idle_cnt == IDLE_LAST) begin
                    state_d = S_FADE;
                end
            end
            S_FADE: begin
                if (power_p) begin
                    state_d = S_OFF;
                end else if (activity) begin
                    state_d = ret_state;
                end else if (fade_cnt == FADE_LAST) begin
                    state_d = S_SLEEP;
                end
            end
            S_SLEEP: begin
                if (power_p) begin
                    state_d = S_OFF;
                end else if (mode_p || sleep_p) begin
                    state_d = S_NORMAL;
                end
            end
            default: state_d = S_OFF;
        endcase
    end

    always_comb begin
        sysOn       = 1'b0;
        sleep       = 1'b0;
        atmospheric = 1'b0;
        lightsSel   = 1'b0;
        threshold   = 6'd0;
        case (state_q)
            S_NORMAL: begin
                sysOn     = 1'b1;
                threshold = THR_NORMAL;
            end
            S_WHITE: begin
                sysOn     = 1'b1;
                lightsSel = 1'b1;
                threshold = THR_NORMAL;
            end
            S_ATMOS, S_FADE: begin
                sysOn       = 1'b1;
                atmospheric = 1'b1;
                threshold   = THR_ATMOS;
            end
            S_SLEEP: begin
                sysOn     = 1'b1;
                sleep     = 1'b1;
                threshold = THR_NORMAL;
            end
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_room_mode_scheduler.sv
module tb_room_mode_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       power_btn;
    logic       mode_btn;
    logic       sleep_btn;
    logic       motion;
    logic       sysOn;
    logic       sleep;
    logic       atmospheric;
    logic       lightsSel;
    logic [5:0] threshold;
    logic [2:0] state;

    localparam logic [2:0] OFF = 3'd0, NRM = 3'd1, WHT = 3'd2,
                           ATM = 3'd3, FAD = 3'd4, SLP = 3'd5;

    typedef struct {
        string       name;
        logic [12:0] vec;
    } exp_t;

    exp_t sb[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    room_mode_scheduler #(
        .IDLE_CYCLES(20),
        .FADE_CYCLES(4),
        .THR_NORMAL (6'd32),
        .THR_ATMOS  (6'd8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .power_btn  (power_btn),
        .mode_btn   (mode_btn),
        .sleep_btn  (sleep_btn),
        .motion     (motion),
        .sysOn      (sysOn),
        .sleep      (sleep),
        .atmospheric(atmospheric),
        .lightsSel  (lightsSel),
        .threshold  (threshold),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Expected output bundle {sysOn, sleep, atmospheric, lightsSel, threshold, state}
    function automatic logic [12:0] model(input logic [2:0] st);
        case (st)
            NRM:     model = {4'b1000, 6'd32, st};
            WHT:     model = {4'b1001, 6'd32, st};
            ATM:     model = {4'b1010, 6'd8,  st};
            FAD:     model = {4'b1010, 6'd8,  st};
            SLP:     model = {4'b1100, 6'd32, st};
            default: model = {4'b0000, 6'd0,  3'd0};
        endcase
    endfunction

    task automatic expect_st(input string name, input logic [2:0] st);
        exp_t e;
        e.name = name;
        e.vec  = model(st);
        sb.push_back(e);
    endtask

    // Drive one cycle of inputs, let the edge happen, settle just past it.
    task automatic cyc(input logic p, input logic m, input logic s, input logic mo);
        power_btn = p;
        mode_btn  = m;
        sleep_btn = s;
        motion    = mo;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares on every falling edge while expectations are pending.
    always @(negedge clk) begin
        exp_t        e;
        logic [12:0] act;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            act = {sysOn, sleep, atmospheric, lightsSel, threshold, state};
            tests_run++;
            if (act !== e.vec) begin
                tests_failed++;
                $display("FAIL %s: got %b required %b", e.name, act, e.vec);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        power_btn = 0; mode_btn = 0; sleep_btn = 0; motion = 0;
        repeat (2) @(posedge clk);
        #1;
        expect_st("reset", OFF);
        rst_n = 1'b1;

        // 1: power on / off
        cyc(0,0,0,1); expect_st("off_motion_ignored", OFF);
        cyc(1,0,0,0); expect_st("pwr_on", NRM);
        cyc(0,0,0,0); expect_st("pwr_release", NRM);
        cyc(1,0,0,0); expect_st("pwr_off", OFF);
        cyc(0,0,0,0);

        // 2: mode cycling and held button
        cyc(1,0,0,0); cyc(0,0,0,0);
        cyc(0,1,0,0); expect_st("mode_white", WHT);
        cyc(0,0,0,0);
        cyc(0,1,0,0); expect_st("mode_atmos", ATM);
        cyc(0,0,0,0);
        cyc(0,1,0,0); expect_st("mode_normal", NRM);
        cyc(0,0,0,0);
        cyc(0,1,0,0); expect_st("mode_held_1", WHT);
        cyc(0,1,0,0);
        cyc(0,1,0,0); expect_st("mode_held_3", WHT);
        cyc(0,0,0,0);
        cyc(1,0,0,0); expect_st("mode_pwr_off", OFF);
        cyc(0,0,0,0);

        // 3: idle timeout, fade length, activity on terminal idle cycle
        cyc(1,0,0,0);
        for (int i = 1; i <= 19; i++) cyc(0,0,0,0);
        expect_st("idle_19", NRM);
        cyc(0,0,0,0); expect_st("idle_timeout", FAD);
        cyc(0,0,0,0); cyc(0,0,0,0);
        cyc(0,0,0,0); expect_st("fade_3", FAD);
        cyc(0,0,0,0); expect_st("fade_to_sleep", SLP);
        cyc(1,0,0,0); expect_st("sleep_pwr_off", OFF);
        cyc(0,0,0,0);

        cyc(1,0,0,0);
        for (int i = 1; i <= 19; i++) cyc(0,0,0,0);
        cyc(0,0,0,1); expect_st("motion_terminal", NRM);
        for (int i = 1; i <= 19; i++) cyc(0,0,0,0);
        expect_st("idle_restart_19", NRM);
        cyc(0,0,0,0); expect_st("idle_restart_to", FAD);
        cyc(1,0,0,0); expect_st("fade_pwr_off", OFF);
        cyc(0,0,0,0);

        // 4: fade return to ATMOS, sleep exit by mode
        cyc(1,0,0,0); cyc(0,0,0,0);
        cyc(0,1,0,0); cyc(0,0,0,0);
        cyc(0,1,0,0); cyc(0,0,0,0);
        cyc(0,0,1,0); expect_st("atmos_sleep_press", FAD);
        cyc(0,0,0,0);
        cyc(0,0,0,1); expect_st("fade_motion_ret", ATM);
        cyc(0,0,0,0);
        cyc(0,0,1,0); cyc(0,0,0,0); cyc(0,0,0,0); cyc(0,0,0,0);
        expect_st("fade2_3", FAD);
        cyc(0,0,0,0); expect_st("fade2_sleep", SLP);
        cyc(0,0,0,1); expect_st("sleep_motion", SLP);
        cyc(0,1,0,0); expect_st("sleep_mode", NRM);
        cyc(0,0,0,0);

        // 5: simultaneous-press priority in WHITE
        cyc(0,1,0,0); cyc(0,0,0,0);
        cyc(1,1,1,0); expect_st("prio_all", OFF);
        cyc(0,0,0,0);
        cyc(1,0,0,0); cyc(0,0,0,0);
        cyc(0,1,0,0); cyc(0,0,0,0);
        cyc(0,1,1,0); expect_st("prio_sleep_mode", FAD);
        cyc(0,0,0,0);

        // 6: async reset mid-FADE, release with power held
        rst_n = 1'b0;
        power_btn = 1'b1;
        #1;
        expect_st("async_reset", OFF);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        expect_st("rst_held_pwr", NRM);
        cyc(1,0,0,0); expect_st("pwr_still_held", NRM);
        cyc(0,0,0,0);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
